// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch line responder: FSM state encoding,
// line geometry and the bus tag used for instruction line reads.
package fetch_pkg;
  localparam int LINE_BYTES = 64;
  localparam int BEATS      = 8;
  localparam int WORDS      = 16;
  localparam int TAG_W      = 13;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int BEAT_W     = $clog2(BEATS);
  localparam int WORD_W     = $clog2(WORDS);
  localparam int LINE_TAG_W = 64 - OFF_W;

  localparam logic [TAG_W-1:0] READ_TAG = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } fetch_st_t;

  function automatic logic [63:0] line_addr(input logic [63:0] pc);
    return {pc[63:OFF_W], {OFF_W{1'b0}}};
  endfunction
endpackage

// File: rtl/fetch_line_responder_if.sv
// Signal bundle between PC generation, the fetch line responder and the bus arbiter.
// Handshakes: a request (fetch_req, bus_reqcyc) is held with stable payload until its
// acknowledge (sig_recvd/fetch_flush, bus_reqack); a response beat transfers only in a
// cycle where bus_respcyc and bus_respack are both high.
interface fetch_line_responder_if #(
  parameter int TAG_W = 13
);
  logic             fetch_req;
  logic [63:0]      fetch_pc;
  logic             fetch_flush;
  logic             sig_recvd;
  logic [31:0]      instr_out;
  logic [63:0]      instr_pc;
  logic             bus_reqcyc;
  logic [63:0]      bus_req;
  logic [TAG_W-1:0] bus_reqtag;
  logic             bus_reqack;
  logic             bus_respcyc;
  logic [63:0]      bus_resp;
  logic             bus_respack;

  modport slave (
    input  fetch_req, fetch_pc, fetch_flush, bus_reqack, bus_respcyc, bus_resp,
    output sig_recvd, instr_out, instr_pc, bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );

  modport master (
    output fetch_req, fetch_pc, fetch_flush, bus_reqack, bus_respcyc, bus_resp,
    input  sig_recvd, instr_out, instr_pc, bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );
endinterface

// File: rtl/fetch_line_buf.sv
// Single 64-byte line buffer: 8x64 beat storage, tag/valid, hit compare and a
// 32-bit word mux that forwards the beat being written this cycle.
module fetch_line_buf
  import fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [BEAT_W-1:0]     wr_beat,
  input  logic [63:0]           wr_data,
  input  logic                  install,
  input  logic                  inval,
  input  logic [LINE_TAG_W-1:0] new_tag,
  input  logic [LINE_TAG_W-1:0] look_tag,
  output logic                  hit,
  input  logic [WORD_W-1:0]     rd_word,
  output logic [31:0]           rd_data
);
  logic [63:0]           beats [BEATS];
  logic                  valid;
  logic [LINE_TAG_W-1:0] tag;
  logic [BEAT_W-1:0]     rd_beat;
  logic [63:0]           beat_data;

  always_ff @(posedge clk) begin
    if (wr_en) beats[wr_beat] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
    end else if (install) begin
      valid <= 1'b1;
      tag   <= new_tag;
    end else if (inval) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (tag == look_tag);

  // The final beat lands in the same cycle its word may be needed for the response.
  assign rd_beat   = rd_word[WORD_W-1:1];
  assign beat_data = (wr_en && (wr_beat == rd_beat)) ? wr_data : beats[rd_beat];
  assign rd_data   = rd_word[0] ? beat_data[63:32] : beat_data[31:0];
endmodule

// File: rtl/fetch_line_responder.sv
// Fetch-side responder: answers PC requests from a one-line buffer, refilling the
// line with an 8-beat bus read on a miss. Redirects squash the pending response.
module fetch_line_responder
  import fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  fetch_line_responder_if.slave  io,
  output fetch_st_t              state_dbg
);
  fetch_st_t         state;
  logic [63:2]       pc_q;
  logic [BEAT_W-1:0] cnt;
  logic              squash;
  logic              hit;
  logic              accept;
  logic              hit_accept;
  logic              miss_accept;
  logic              fill_beat;
  logic              last_beat;
  logic [WORD_W-1:0] rd_word;
  logic [31:0]       word;
  logic              unused_pc_lsb;

  assign unused_pc_lsb = ^io.fetch_pc[1:0];

  assign accept      = (state == IDLE) && io.fetch_req && !io.fetch_flush;
  assign hit_accept  = accept && hit;
  assign miss_accept = accept && !hit;
  assign fill_beat   = (state == FILL) && io.bus_respcyc;
  assign last_beat   = fill_beat && (cnt == BEAT_W'(BEATS - 1));
  assign rd_word     = (state == IDLE) ? io.fetch_pc[OFF_W-1:2] : pc_q[OFF_W-1:2];

  fetch_line_buf u_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (fill_beat),
    .wr_beat  (cnt),
    .wr_data  (io.bus_resp),
    .install  (last_beat),
    .inval    (miss_accept),
    .new_tag  (pc_q[63:OFF_W]),
    .look_tag (io.fetch_pc[63:OFF_W]),
    .hit      (hit),
    .rd_word  (rd_word),
    .rd_data  (word)
  );

  // A redirect arriving in the response cycle still cancels that response.
  assign io.sig_recvd   = (state == RESP) && !io.fetch_flush;
  assign io.bus_respack = fill_beat;
  assign io.bus_reqtag  = READ_TAG;
  assign state_dbg      = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pc_q          <= '0;
      cnt           <= '0;
      squash        <= 1'b0;
      io.instr_out  <= '0;
      io.instr_pc   <= '0;
      io.bus_reqcyc <= 1'b0;
      io.bus_req    <= '0;
    end else begin
      case (state)
        IDLE: begin
          squash <= 1'b0;
          if (hit_accept) begin
            io.instr_out <= word;
            io.instr_pc  <= {io.fetch_pc[63:2], 2'b00};
            state        <= RESP;
          end else if (miss_accept) begin
            pc_q          <= io.fetch_pc[63:2];
            io.bus_reqcyc <= 1'b1;
            io.bus_req    <= line_addr(io.fetch_pc);
            state         <= REQ;
          end
        end
        REQ: begin
          if (io.fetch_flush) squash <= 1'b1;
          if (io.bus_reqack) begin
            io.bus_reqcyc <= 1'b0;
            cnt           <= '0;
            state         <= FILL;
          end
        end
        FILL: begin
          if (io.fetch_flush) squash <= 1'b1;
          if (io.bus_respcyc) begin
            cnt <= cnt + BEAT_W'(1);
            // The line installs even when squashed; only the response is dropped.
            if (last_beat) begin
              if (squash || io.fetch_flush) begin
                state <= IDLE;
              end else begin
                io.instr_out <= word;
                io.instr_pc  <= {pc_q, 2'b00};
                state        <= RESP;
              end
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_line_responder.sv
// Bench for fetch_line_responder: directed scenarios plus a randomized phase,
// scored against a line-buffer reference model and a sparse memory image.
module tb_fetch_line_responder;
  import fetch_pkg::*;

  logic      clk = 1'b0;
  logic      reset = 1'b1;
  fetch_st_t state_dbg;

  fetch_line_responder_if #(.TAG_W(TAG_W)) rif();

  fetch_line_responder dut (
    .clk       (clk),
    .reset     (reset),
    .io        (rif),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: got no end of test, expected finish before 500000");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [95:0] exp_q[$];
  logic [63:0] mem [logic [63:0]];
  logic        m_valid = 1'b0;
  logic [57:0] m_tag = '0;
  logic [31:0] last_instr = '0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
    return mem[a];
  endfunction

  // Little-endian word select: word 2k is beat k low half, word 2k+1 its high half.
  function automatic logic [31:0] ref_word(input logic [63:0] pc);
    logic [63:0] line;
    logic [63:0] beat;
    line = pc & ~64'h3f;
    beat = mem_rd(line + 64'(pc[5:3]) * 64'd8);
    return pc[2] ? beat[63:32] : beat[31:0];
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    logic [95:0] e;
    if (!reset && rif.sig_recvd === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got sig_recvd=1 pc=%0h expected no response", rif.instr_pc);
      end else begin
        e = exp_q.pop_front();
        check("instr_out", 96'(rif.instr_out), 96'(e[31:0]));
        check("instr_pc", 96'(rif.instr_pc), 96'(e[95:32]));
        last_instr = e[31:0];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_reqcyc(output bit found);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (rif.bus_reqcyc === 1'b1) found = 1'b1;
    end
  endtask

  task automatic do_fetch(input logic [63:0] pc, input int ack_dly, input int flush_beat);
    logic        hit_exp;
    logic [63:0] line;
    bit          found;
    hit_exp = m_valid && (m_tag == pc[63:6]);
    line    = {pc[63:6], 6'b0};
    rif.fetch_req = 1'b1;
    rif.fetch_pc  = pc;
    if (hit_exp) begin
      exp_q.push_back({pc[63:2], 2'b00, ref_word(pc)});
      @(posedge clk);
      @(negedge clk);
      check("hit_pulse", 96'(rif.sig_recvd), 96'd1);
      check("hit_no_bus", 96'(rif.bus_reqcyc), 96'd0);
      tick();
      rif.fetch_req = 1'b0;
    end else begin
      if (flush_beat < 0) exp_q.push_back({pc[63:2], 2'b00, ref_word(pc)});
      wait_reqcyc(found);
      check("reqcyc_raise", 96'(found), 96'd1);
      check("bus_req", 96'(rif.bus_req), 96'(line));
      check("bus_reqtag", 96'(rif.bus_reqtag), 96'(READ_TAG));
      for (int d = 0; d < ack_dly; d++) begin
        tick();
        @(negedge clk);
        check("req_hold", {31'b0, rif.bus_reqcyc, rif.bus_req}, {31'b0, 1'b1, line});
      end
      tick();
      rif.bus_reqack = 1'b1;
      tick();
      rif.bus_reqack = 1'b0;
      for (int k = 0; k < 8; k++) begin
        repeat ($urandom_range(0, 1)) tick();
        rif.bus_respcyc = 1'b1;
        rif.bus_resp    = mem_rd(line + 64'(k) * 64'd8);
        if (k == flush_beat) begin
          rif.fetch_flush = 1'b1;
          rif.fetch_req   = 1'b0;
        end
        @(negedge clk);
        check("beat_ack", 96'(rif.bus_respack), 96'd1);
        tick();
        rif.bus_respcyc = 1'b0;
        rif.fetch_flush = 1'b0;
      end
      m_valid = 1'b1;
      m_tag   = pc[63:6];
      @(negedge clk);
      check("miss_pulse", 96'(rif.sig_recvd), 96'(flush_beat < 0));
      tick();
      rif.fetch_req = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sig_recvd"}, 96'(rif.sig_recvd), 96'd0);
    check({tag, "_instr_out"}, 96'(rif.instr_out), 96'd0);
    check({tag, "_instr_pc"}, 96'(rif.instr_pc), 96'd0);
    check({tag, "_reqcyc"}, 96'(rif.bus_reqcyc), 96'd0);
    check({tag, "_bus_req"}, 96'(rif.bus_req), 96'd0);
    check({tag, "_respack"}, 96'(rif.bus_respack), 96'd0);
    check({tag, "_state"}, 96'(state_dbg), 96'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    rif.fetch_req   = 1'b0;
    rif.fetch_pc    = '0;
    rif.fetch_flush = 1'b0;
    rif.bus_reqack  = 1'b0;
    rif.bus_respcyc = 1'b0;
    rif.bus_resp    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;
    tick();

    // cold miss, then hits in the same line (no bus activity)
    do_fetch(64'h1000, 0, -1);
    do_fetch(64'h1008, 0, -1);
    do_fetch(64'h103C, 0, -1);

    // redirect during fill: line still installs, no response
    do_fetch(64'h2000, 0, 4);
    do_fetch(64'h2004, 0, -1);

    // redirect in IDLE wins over the request
    rif.fetch_req   = 1'b1;
    rif.fetch_pc    = 64'h1000;
    rif.fetch_flush = 1'b1;
    tick();
    rif.fetch_flush = 1'b0;
    rif.fetch_req   = 1'b0;
    @(negedge clk);
    check("idle_flush_pulse", 96'(rif.sig_recvd), 96'd0);
    check("idle_flush_bus", 96'(rif.bus_reqcyc), 96'd0);
    check("hold_instr", 96'(rif.instr_out), 96'(last_instr));
    tick();

    // redirect in the response cycle suppresses the pulse
    rif.fetch_req = 1'b1;
    rif.fetch_pc  = 64'h2008;
    tick();
    rif.fetch_flush = 1'b1;
    rif.fetch_req   = 1'b0;
    @(negedge clk);
    check("resp_flush_pulse", 96'(rif.sig_recvd), 96'd0);
    tick();
    rif.fetch_flush = 1'b0;

    // stray response beat while idle: no ack, buffer untouched
    rif.bus_respcyc = 1'b1;
    rif.bus_resp    = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    check("idle_respack", 96'(rif.bus_respack), 96'd0);
    tick();
    rif.bus_respcyc = 1'b0;
    do_fetch(64'h2010, 0, -1);

    // slow request acknowledge
    do_fetch(64'h1000, 5, -1);

    // reset in the middle of a fill
    rif.fetch_req = 1'b1;
    rif.fetch_pc  = 64'h3000;
    wait_reqcyc(found);
    check("rst_reqcyc", 96'(found), 96'd1);
    tick();
    rif.bus_reqack = 1'b1;
    tick();
    rif.bus_reqack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rif.bus_respcyc = 1'b1;
      rif.bus_resp    = mem_rd(64'h3000 + 64'(k) * 64'd8);
      tick();
    end
    rif.bus_respcyc = 1'b1;
    rif.bus_resp    = mem_rd(64'h3018);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    rif.fetch_req = 1'b0;
    m_valid       = 1'b0;
    last_instr    = '0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    for (int k = 4; k < 8; k++) begin
      rif.bus_respcyc = 1'b1;
      rif.bus_resp    = mem_rd(64'h3000 + 64'(k) * 64'd8);
      @(negedge clk);
      check("dropped_beat_ack", 96'(rif.bus_respack), 96'd0);
      tick();
    end
    rif.bus_respcyc = 1'b0;
    do_fetch(64'h1000, 0, -1);

    // randomized traffic over a few lines
    for (int n = 0; n < 40; n++) begin
      logic [63:0] pc;
      int          fb;
      pc = 64'h1000 * 64'($urandom_range(1, 4)) + 64'($urandom_range(0, 15)) * 64'd4
           + 64'($urandom_range(0, 3));
      fb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      do_fetch(pc, int'($urandom_range(0, 3)), fb);
    end

    repeat (3) tick();
    check("queue_empty", 96'(exp_q.size()), 96'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
